// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC request scheduler: default geometry and FSM state encoding.
package cordic_pkg;

  localparam int DEFAULT_NUM_REQ  = 4;
  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_PIPE_LAT = 18;
  localparam int DEFAULT_TAG_W    = $clog2(DEFAULT_NUM_REQ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Width of the in-flight counter: enough for every delay-line stage plus the engine-input stage.
  function automatic int inflight_w(input int pipe_lat);
    return $clog2(pipe_lat + 2) + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and wraps around.
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int TAG_W   = DEFAULT_TAG_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [TAG_W-1:0]   grant_idx,
  output logic               grant_any
);

  always_comb begin
    logic [TAG_W-1:0] idx;
    // NOTE: every output gets a default before the loop so no path leaves a value unassigned,
    // which would otherwise infer a latch.
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = TAG_W'((int'(ptr) + i) % NUM_REQ);
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_req_scheduler.sv
// Shares one pipelined cordic_engine between NUM_REQ requesters; a valid/tag delay line stands in
// for the output-valid the engine lacks, and routes each result back to its owner.
module cordic_req_scheduler
  import cordic_pkg::*;
#(
  parameter int NUM_REQ  = DEFAULT_NUM_REQ,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int PIPE_LAT = DEFAULT_PIPE_LAT,
  parameter int TAG_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_angle,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         eng_angle,
  output logic                      eng_valid,
  input  logic [DATA_W-1:0]         eng_sine,
  input  logic [DATA_W-1:0]         eng_cosine,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_sine,
  output logic [DATA_W-1:0]         resp_cosine,
  output logic                      idle
);

  localparam int CNT_W = inflight_w(PIPE_LAT);

  logic [1:0]                     state_q, state_d;
  logic [TAG_W-1:0]               ptr_q, ptr_d;
  logic [DATA_W-1:0]              eng_angle_q, eng_angle_d;
  logic                           eng_valid_q, eng_valid_d;
  logic [TAG_W-1:0]               eng_tag_q, eng_tag_d;
  logic [PIPE_LAT-1:0]            dl_valid_q, dl_valid_d;
  logic [PIPE_LAT-1:0][TAG_W-1:0] dl_tag_q, dl_tag_d;
  logic [NUM_REQ-1:0]             resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]              resp_sine_q, resp_sine_d;
  logic [DATA_W-1:0]              resp_cosine_q, resp_cosine_d;
  logic [CNT_W-1:0]               inflight_q, inflight_d;

  logic               grant_en;
  logic [NUM_REQ-1:0] grant;
  logic [TAG_W-1:0]   grant_idx;
  logic               transfer;
  logic               retire;
  logic [TAG_W-1:0]   retire_tag;

  // Grants only while running with enable still high, so a falling enable blocks that cycle's grant.
  assign grant_en = (state_q == ST_RUN) && enable;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W)
  ) u_arb (
    .req       (req_valid & {NUM_REQ{grant_en}}),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (transfer)
  );

  assign retire     = dl_valid_q[PIPE_LAT-1];
  assign retire_tag = dl_tag_q[PIPE_LAT-1];

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    eng_angle_d   = eng_angle_q;
    eng_tag_d     = eng_tag_q;
    eng_valid_d   = transfer;
    resp_valid_d  = '0;
    resp_sine_d   = resp_sine_q;
    resp_cosine_d = resp_cosine_q;
    inflight_d    = inflight_q;

    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (enable)               state_d = ST_RUN;
        else if (inflight_q == '0) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase

    if (transfer) begin
      ptr_d       = grant_idx;
      eng_angle_d = req_angle[int'(grant_idx)*DATA_W +: DATA_W];
      eng_tag_d   = grant_idx;
    end

    dl_valid_d = {dl_valid_q[PIPE_LAT-2:0], eng_valid_q};
    dl_tag_d   = {dl_tag_q[PIPE_LAT-2:0], eng_tag_q};

    // The last delay-line stage lines up with the engine outputs being valid.
    if (retire) begin
      resp_valid_d[retire_tag] = 1'b1;
      resp_sine_d              = eng_sine;
      resp_cosine_d            = eng_cosine;
    end

    case ({transfer, retire})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    // The delay line is reset too: stale valid bits would emit responses nobody asked for.
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= TAG_W'(NUM_REQ - 1);
      eng_angle_q   <= '0;
      eng_valid_q   <= 1'b0;
      eng_tag_q     <= '0;
      dl_valid_q    <= '0;
      dl_tag_q      <= '0;
      resp_valid_q  <= '0;
      resp_sine_q   <= '0;
      resp_cosine_q <= '0;
      inflight_q    <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      eng_angle_q   <= eng_angle_d;
      eng_valid_q   <= eng_valid_d;
      eng_tag_q     <= eng_tag_d;
      dl_valid_q    <= dl_valid_d;
      dl_tag_q      <= dl_tag_d;
      resp_valid_q  <= resp_valid_d;
      resp_sine_q   <= resp_sine_d;
      resp_cosine_q <= resp_cosine_d;
      inflight_q    <= inflight_d;
    end
  end

  assign req_ready   = grant;
  assign eng_angle   = eng_angle_q;
  assign eng_valid   = eng_valid_q;
  assign resp_valid  = resp_valid_q;
  assign resp_sine   = resp_sine_q;
  assign resp_cosine = resp_cosine_q;
  assign idle        = (state_q == ST_IDLE) && (inflight_q == '0) && !eng_valid_q;

endmodule
